// File: rtl/nl_engine_if.sv
// Valid/ready element stream used on both sides of the nonlinearity engine.
interface nl_engine_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/nl_engine.sv
// Streaming elementwise nonlinearity (bypass/ReLU/leaky/clip) with run control
// driven by the NL register block and status returned to it.
module nl_engine #(
    parameter int DW         = 16,
    parameter int FRAC       = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] data_wid,
    input  logic [15:0] data_hei,
    input  logic [15:0] data_ch,
    input  logic [15:0] nl_type,
    input  logic [15:0] input_data_format,
    nl_engine_if.slave  in_s,
    nl_engine_if.master out_m,
    output logic [15:0] output_wid,
    output logic [15:0] output_hei,
    output logic [15:0] output_ch,
    output logic [15:0] output_data_length,
    output logic        busy,
    output logic        done
);
    localparam logic [DW-1:0] CLIP_MAX = DW'(6 << FRAC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [47:0]         total;
    logic [47:0]         in_cnt;
    logic [47:0]         req_total;
    logic [1:0]          mode;
    logic                unsgn;
    logic [DW-1:0]       data_p1;
    logic                vld_p1;
    logic                in_ready;
    logic                in_fire;
    logic                out_fire;
    logic                unused_cfg;

    function automatic logic [DW-1:0] nl_apply(input logic [DW-1:0] x,
                                               input logic [1:0]    sel,
                                               input logic          uns);
        logic signed [DW-1:0] xs;
        logic [DW-1:0]        y;
        xs = $signed(x);
        y  = x;
        if (uns) begin
            if (sel == 2'd3 && x > CLIP_MAX) y = CLIP_MAX;
        end else begin
            case (sel)
                2'd1:    if (xs < 0) y = '0;
                2'd2:    if (xs < 0) y = xs >>> LEAK_SHIFT;
                2'd3:    if (xs < 0) y = '0; else if (x > CLIP_MAX) y = CLIP_MAX;
                default: y = x;
            endcase
        end
        return y;
    endfunction

    assign unused_cfg = ^{nl_type[15:2], input_data_format[15:1]};
    assign req_total  = 48'(data_wid) * 48'(data_hei) * 48'(data_ch);

    // Single output register: an input may land whenever it is empty or draining.
    assign in_ready   = (state == RUN) && (!vld_p1 || out_m.ready);
    assign in_fire    = in_s.valid && in_ready;
    assign out_fire   = vld_p1 && out_m.ready;
    assign in_s.ready = in_ready;
    assign out_m.data = data_p1;
    assign out_m.valid = vld_p1;
    assign busy       = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            total              <= '0;
            in_cnt             <= '0;
            mode               <= '0;
            unsgn              <= 1'b0;
            data_p1            <= '0;
            vld_p1             <= 1'b0;
            output_wid         <= '0;
            output_hei         <= '0;
            output_ch          <= '0;
            output_data_length <= '0;
            done               <= 1'b0;
        end else begin
            done <= 1'b0;
            // Stage p1: result register, loaded one cycle after the input fires.
            if (out_fire && !in_fire) vld_p1 <= 1'b0;
            if (in_fire) begin
                data_p1 <= nl_apply(in_s.data, mode, unsgn);
                vld_p1  <= 1'b1;
            end
            if (out_fire && output_data_length != 16'hFFFF)
                output_data_length <= output_data_length + 16'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        output_wid         <= data_wid;
                        output_hei         <= data_hei;
                        output_ch          <= data_ch;
                        mode               <= nl_type[1:0];
                        unsgn              <= input_data_format[0];
                        total              <= req_total;
                        in_cnt             <= '0;
                        output_data_length <= '0;
                        state              <= (req_total == 48'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + 48'd1;
                        if (in_cnt + 48'd1 == total) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld_p1 || out_fire) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nl_engine.sv
// Randomised and directed checks of nl_engine against a plain-arithmetic model.
module tb_nl_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_wid = '0, data_hei = '0, data_ch = '0;
    logic [15:0] nl_type = '0, input_data_format = '0;
    logic [15:0] output_wid, output_hei, output_ch, output_data_length;
    logic        busy, done;

    nl_engine_if #(.DW(16)) in_if ();
    nl_engine_if #(.DW(16)) out_if ();

    nl_engine #(.DW(16), .FRAC(8), .LEAK_SHIFT(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .data_wid           (data_wid),
        .data_hei           (data_hei),
        .data_ch            (data_ch),
        .nl_type            (nl_type),
        .input_data_format  (input_data_format),
        .in_s               (in_if),
        .out_m              (out_if),
        .output_wid         (output_wid),
        .output_hei         (output_hei),
        .output_ch          (output_ch),
        .output_data_length (output_data_length),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] stim[$];
    logic [15:0] got[$];
    logic [15:0] edge_vals[6];
    int done_cnt, done_cyc, stab_viol, rdy_viol, lat_viol, extra, ready_seen;
    bit timeout;

    // Reference: signed/unsigned interpretation, then the textbook nonlinearity.
    function automatic logic [15:0] nl_ref(input logic [15:0] x, input int sel, input bit uns);
        int v;
        int y;
        if (uns) begin
            v = int'(x);
            y = (sel == 3 && v > 1536) ? 1536 : v;
        end else begin
            v = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
            case (sel)
                1:       y = (v < 0) ? 0 : v;
                2:       y = (v < 0) ? -((-v + 7) / 8) : v;
                3:       y = (v < 0) ? 0 : ((v > 1536) ? 1536 : v);
                default: y = v;
            endcase
        end
        return y[15:0];
    endfunction

    task automatic run_stream(input logic [15:0] w, input logic [15:0] h, input logic [15:0] c,
                              input logic [15:0] t, input logic [15:0] f,
                              input int rdy_mode, input int vld_mode, input int mid_start);
        int idx, cyc, tail;
        bit pend, prev_stall, fin;
        logic [15:0] pend_val, prev_data;
        got.delete();
        done_cnt = 0; done_cyc = -1; stab_viol = 0; rdy_viol = 0; lat_viol = 0;
        extra = 0; ready_seen = 0; timeout = 0;
        idx = 0; cyc = 0; tail = 0; pend = 0; prev_stall = 0; fin = 0;
        pend_val = '0; prev_data = '0;
        @(negedge clk);
        data_wid = w; data_hei = h; data_ch = c; nl_type = t; input_data_format = f;
        start = 1'b1; in_if.valid = 1'b0; out_if.ready = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start);
            if (start) begin data_wid = 16'd7; data_hei = 16'd7; data_ch = 16'd7; end
            case (rdy_mode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = (cyc % 3 == 1);
                default: out_if.ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < stim.size()) begin
                in_if.valid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                in_if.data  = stim[idx];
            end else begin
                in_if.valid = 1'b1;
                in_if.data  = 16'h1234;
            end
            #1;
            if (in_if.ready) ready_seen++;
            if (pend) begin
                if (!(out_if.valid && out_if.data == pend_val)) lat_viol++;
                pend = 0;
            end
            if (prev_stall && (!out_if.valid || out_if.data !== prev_data)) stab_viol++;
            if (out_if.valid && !out_if.ready && in_if.ready) rdy_viol++;
            if (out_if.valid && out_if.ready) got.push_back(out_if.data);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (in_if.valid && in_if.ready) begin
                if (idx >= stim.size()) extra++;
                else begin
                    pend = 1;
                    pend_val = nl_ref(stim[idx], int'(t[1:0]), f[0]);
                    idx++;
                end
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            if (done_cnt > 0) tail++;
            if (cyc >= 400 && done_cnt == 0) timeout = 1;
            fin = (tail >= 3) || (cyc >= 400);
        end
        start = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_if.valid = 1'b1; in_if.data = 16'h0100; out_if.ready = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_if.valid, out_if.data, in_if.ready, busy, done} !== 20'd0) begin
            failures++;
            $display("FAIL reset_stream got=%h exp=0", {out_if.valid, out_if.data, in_if.ready, busy, done});
        end
        checks++;
        if ({output_wid, output_hei, output_ch, output_data_length} !== 64'd0) begin
            failures++;
            $display("FAIL reset_status got=%h exp=0", {output_wid, output_hei, output_ch, output_data_length});
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({in_if.ready, out_if.valid, busy, done} !== 4'd0) begin
                failures++;
                $display("FAIL idle_accept cyc=%0d got=%b exp=0000", i, {in_if.ready, out_if.valid, busy, done});
            end
        end
        in_if.valid = 1'b0;
    endtask

    task automatic test_relu();
        logic [15:0] exp_q[$];
        stim = '{16'h0100, 16'hFF00, 16'h0000, 16'h7FFF};
        exp_q = '{16'h0100, 16'h0000, 16'h0000, 16'h7FFF};
        run_stream(16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 0, 0, -1);
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL relu_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL relu_out%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (lat_viol != 0 || done_cnt != 1 || timeout) begin
            failures++; $display("FAIL relu_timing lat_viol=%0d done_cnt=%0d timeout=%0d exp=0/1/0", lat_viol, done_cnt, timeout);
        end
        checks++;
        if ({output_wid, output_hei, output_ch, output_data_length} !== {16'd2, 16'd2, 16'd1, 16'd4}) begin
            failures++;
            $display("FAIL relu_status got=%0d/%0d/%0d len=%0d exp=2/2/1 len=4", output_wid, output_hei, output_ch, output_data_length);
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin failures++; $display("FAIL relu_after extra=%0d busy=%b exp=0/0", extra, busy); end
    endtask

    task automatic test_leaky_clip();
        logic [15:0] exp_q[$];
        stim = '{16'hFFF8, 16'hFFFF, 16'h0010};
        exp_q = '{16'hFFFF, 16'hFFFF, 16'h0010};
        run_stream(16'd3, 16'd1, 16'd1, 16'd2, 16'd0, 0, 0, -1);
        checks++;
        if (got.size() != 3) begin failures++; $display("FAIL leaky_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL leaky_out%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        stim = '{16'h0700, 16'h0500, 16'h8000};
        exp_q = '{16'h0600, 16'h0500, 16'h0000};
        run_stream(16'd3, 16'd1, 16'd1, 16'd3, 16'd0, 0, 0, -1);
        checks++;
        if (got.size() != 3) begin failures++; $display("FAIL clip_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL clip_out%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_unsigned();
        stim = '{16'hFF00};
        run_stream(16'd1, 16'd1, 16'd1, 16'hFFFF, 16'h0003, 0, 0, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 16'h0600) begin
            failures++; $display("FAIL uns_clip got=%h n=%0d exp=0600", (got.size() > 0) ? got[0] : 16'hxxxx, got.size());
        end
        run_stream(16'd1, 16'd1, 16'd1, 16'h0001, 16'h0001, 0, 0, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 16'hFF00) begin
            failures++; $display("FAIL uns_relu got=%h n=%0d exp=FF00", (got.size() > 0) ? got[0] : 16'hxxxx, got.size());
        end
    endtask

    task automatic test_backpressure();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
        run_stream(16'd1, 16'd1, 16'd8, 16'd0, 16'd0, 1, 0, -1);
        checks++;
        if (got.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== stim[i]) begin failures++; $display("FAIL bp_out%0d got=%h exp=%h", i, got[i], stim[i]); end
        end
        checks++;
        if (stab_viol != 0 || rdy_viol != 0 || lat_viol != 0) begin
            failures++; $display("FAIL bp_handshake stab=%0d rdy=%0d lat=%0d exp=0/0/0", stab_viol, rdy_viol, lat_viol);
        end
        checks++;
        if (output_data_length !== 16'd8 || done_cnt != 1) begin
            failures++; $display("FAIL bp_status len=%0d done_cnt=%0d exp=8/1", output_data_length, done_cnt);
        end
    endtask

    task automatic test_zero_dims();
        stim.delete();
        run_stream(16'd0, 16'd4, 16'd4, 16'd1, 16'd0, 0, 0, -1);
        checks++;
        if (done_cyc != 2 || done_cnt != 1) begin
            failures++; $display("FAIL zero_done cyc=%0d cnt=%0d exp=2/1", done_cyc, done_cnt);
        end
        checks++;
        if (ready_seen != 0 || got.size() != 0 || extra != 0) begin
            failures++; $display("FAIL zero_accept ready=%0d out=%0d extra=%0d exp=0/0/0", ready_seen, got.size(), extra);
        end
        checks++;
        if ({output_wid, output_hei, output_ch, output_data_length} !== {16'd0, 16'd4, 16'd4, 16'd0}) begin
            failures++;
            $display("FAIL zero_status got=%0d/%0d/%0d len=%0d exp=0/4/4 len=0", output_wid, output_hei, output_ch, output_data_length);
        end
    endtask

    task automatic test_start_in_run();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
        run_stream(16'd2, 16'd2, 16'd2, 16'd1, 16'd0, 0, 0, 2);
        checks++;
        if (got.size() != 8 || extra != 0 || done_cnt != 1) begin
            failures++; $display("FAIL restart_count got=%0d extra=%0d done=%0d exp=8/0/1", got.size(), extra, done_cnt);
        end
        checks++;
        if ({output_wid, output_ch, output_data_length} !== {16'd2, 16'd2, 16'd8}) begin
            failures++; $display("FAIL restart_status wid=%0d ch=%0d len=%0d exp=2/2/8", output_wid, output_ch, output_data_length);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] x;
        int sel;
        @(negedge clk);
        data_wid = 16'd1; data_hei = 16'd1; data_ch = 16'd4; nl_type = 16'd0; input_data_format = 16'd0;
        start = 1'b1; out_if.ready = 1'b0;
        @(negedge clk);
        start = 1'b0; in_if.valid = 1'b1; in_if.data = 16'h0100;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_if.valid, out_if.data, in_if.ready, busy, done} !== 20'd0) begin
            failures++; $display("FAIL midrst_stream got=%h exp=0", {out_if.valid, out_if.data, in_if.ready, busy, done});
        end
        checks++;
        if ({output_wid, output_hei, output_ch, output_data_length} !== 64'd0) begin
            failures++; $display("FAIL midrst_status got=%h exp=0", {output_wid, output_hei, output_ch, output_data_length});
        end
        @(negedge clk);
        rst = 1'b1; in_if.valid = 1'b0; out_if.ready = 1'b1;
        x = 16'($urandom);
        sel = int'($urandom_range(0, 3));
        stim = '{x};
        run_stream(16'd1, 16'd1, 16'd1, 16'(sel), 16'd0, 0, 0, -1);
        checks++;
        if (got.size() != 1 || got[0] !== nl_ref(x, sel, 1'b0) || done_cnt != 1) begin
            failures++;
            $display("FAIL midrst_rerun n=%0d got=%h exp=%h done=%0d", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, nl_ref(x, sel, 1'b0), done_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] w, h, c, t, f, e;
        int n;
        for (int r = 0; r < 8; r++) begin
            w = 16'($urandom_range(1, 3)); h = 16'($urandom_range(1, 3)); c = 16'($urandom_range(1, 3));
            t = 16'($urandom); f = 16'($urandom);
            n = int'(w) * int'(h) * int'(c);
            stim.delete();
            for (int i = 0; i < n; i++)
                stim.push_back(($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom));
            run_stream(w, h, c, t, f, 2, 1, -1);
            checks++;
            if (got.size() != n || timeout || extra != 0) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d timeout=%0d extra=%0d", r, got.size(), n, timeout, extra);
            end
            for (int i = 0; i < got.size() && i < n; i++) begin
                e = nl_ref(stim[i], int'(t[1:0]), f[0]);
                checks++;
                if (got[i] !== e) begin
                    failures++; $display("FAIL rand%0d_out%0d in=%h mode=%0d uns=%0d got=%h exp=%h", r, i, stim[i], t[1:0], f[0], got[i], e);
                end
            end
            checks++;
            if (stab_viol != 0 || rdy_viol != 0 || lat_viol != 0 || done_cnt != 1 || output_data_length !== 16'(n)) begin
                failures++;
                $display("FAIL rand%0d_proto stab=%0d rdy=%0d lat=%0d done=%0d len=%0d exp=0/0/0/1/%0d",
                         r, stab_viol, rdy_viol, lat_viol, done_cnt, output_data_length, n);
            end
        end
    endtask

    initial begin
        edge_vals = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0600, 16'h0601};
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
        test_reset();
        test_relu();
        test_leaky_clip();
        test_unsigned();
        test_backpressure();
        test_zero_dims();
        test_start_in_run();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nl_engine.md
Name: nl_engine

Overview:
- Streaming elementwise nonlinearity stage that sits directly downstream of the NL register block.
- Consumes the NL configuration fields (data_wid/hei/ch, nl_type, input_data_format) and applies the selected nonlinearity to a 16-bit feature-map stream.
- Returns output dimensions and the emitted word count to the register block as read-only status.
- Feeds the downstream write-back/buffer stage over a valid/ready stream.

Parameters:
- DW, 16, data word width (signed fixed point unless the unsigned format is selected)
- FRAC, 8, fractional bits; sets the clip ceiling CLIP_MAX = 6 << FRAC
- LEAK_SHIFT, 3, arithmetic right-shift applied to negatives in leaky mode

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE only)
- data_wid  in  16  input width
- data_hei  in  16  input height
- data_ch  in  16  input channels
- nl_type  in  16  [1:0]: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU; [15:2] ignored
- input_data_format  in  16  bit0: 0 signed, 1 unsigned; other bits ignored
- in_data  in  DW  input element
- in_valid  in  1  input element valid
- in_ready  out  1  engine accepts the input element
- out_data  out  DW  result element
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- output_wid  out  16  latched data_wid
- output_hei  out  16  latched data_hei
- output_ch  out  16  latched data_ch
- output_data_length  out  16  words emitted in current/last run, saturating at 16'hFFFF
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst low, async): FSM to IDLE; all outputs 0; counters cleared. Reset mid-run discards the in-flight element, and out_valid drops immediately.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start latches data_wid/hei/ch, nl_type[1:0] and format bit0.
  - Computes total = wid*hei*ch as a 48-bit unsigned value.
  - Clears in_cnt and output_data_length.
  - output_wid/hei/ch update on the same edge.
  - If total == 0, go to DONE; else go to RUN.
  - start in any other state is ignored.
- RUN:
  - in_ready = !out_valid || out_ready (single output register, no bubble at full throughput).
  - Input fire = in_valid && in_ready; on fire, the result is registered into out_data and out_valid is set next cycle (latency 1).
  - in_cnt increments on each fire; the fire that makes in_cnt == total moves the FSM to DRAIN.
- DRAIN: in_ready = 0; stay until the output register empties (out_valid low, or an output fire this cycle), then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. Latched dims and output_data_length persist until the next start.
- Outside RUN, in_ready = 0. Elements beyond total are never accepted.
- Output register:
  - An output fire with no concurrent input fire clears out_valid.
  - Concurrent input fire and output fire reloads the register, and out_valid stays 1.
  - out_data holds stable while out_valid && !out_ready.
- output_data_length increments on each output fire and saturates at FFFF (no wrap).
- Nonlinearity function, signed mode (x as signed DW):
  - bypass: y = x
  - ReLU: y = x<0 ? 0 : x
  - leaky: y = x<0 ? x >>> LEAK_SHIFT : x. Arithmetic shift, floor rounding, so -1 maps to -1.
  - clip: y = x<0 ? 0 : min(x, CLIP_MAX)
- Nonlinearity function, unsigned mode: x is treated as non-negative. Bypass, ReLU and leaky all give y = x; clip gives y = min(x, CLIP_MAX) with an unsigned compare.
- busy = (state == RUN || state == DRAIN).

Test Plan:
- Reset and idle: reset, then no start. Required: all outputs 0, in_ready 0; in_valid=1 is never accepted.
- ReLU signed, dims 2x2x1, inputs {0x0100, 0xFF00, 0x0000, 0x7FFF}, out_ready held 1. Required:
  - outputs {0x0100, 0x0000, 0x0000, 0x7FFF}, each 1 cycle after its input
  - done pulses once
  - output_data_length = 4; output_wid/hei/ch = 2/2/1
- Leaky and clip signed, dims 3x1x1:
  - leaky inputs {0xFFF8, 0xFFFF, 0x0010} produce {0xFFFF, 0xFFFF, 0x0010}
  - clip inputs {0x0700, 0x0500, 0x8000} produce {0x0600, 0x0500, 0x0000}
- Unsigned format, clip, input 0xFF00: output 0x0600. With ReLU selected, input 0xFF00 passes as 0xFF00.
- Backpressure: 1x1x8 bypass with out_ready toggling 1,0,0,1,...
  - out_data stable while stalled
  - no loss or duplication; 8 words emitted in order
  - in_ready low whenever out_valid && !out_ready
- Boundaries:
  - dims 0x4x4: start leads to done 2 cycles later with no in_ready.
  - start during RUN is ignored.
  - rst asserted mid-run: immediate IDLE and zeroed outputs. A fresh start then completes a 1x1x1 run correctly.
